// File: rtl/recip_pkg.sv
// Shared types and Q1.15 constants for the reciprocal unit controller.
package recip_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    MUL1,
    MUL2,
    DONE
  } state_t;

  localparam logic [15:0] ONE_Q15 = 16'h8000;
  localparam logic [16:0] TWO_Q15 = 17'h10000;
  localparam logic [15:0] SAT_Q15 = 16'hFFFF;

  // x0 = 0.5 + seed/256; seed bit 7 carries no weight.
  function automatic logic [15:0] seed_expand(input logic [6:0] s);
    return (ONE_Q15 >> 1) | {2'b00, s, 7'b0};
  endfunction

endpackage

// File: rtl/recip_nr_ctrl_if.sv
// Request/acknowledge port to the shared 16x16 multiplier.
interface recip_nr_ctrl_if;
  logic        mul_req;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic        mul_ack;
  logic [31:0] mul_p;

  modport master (output mul_req, mul_a, mul_b, input mul_ack, mul_p);
  modport slave  (input mul_req, mul_a, mul_b, output mul_ack, mul_p);
endinterface

// File: rtl/recip_nr_ctrl.sv
// Newton-Raphson reciprocal sequencer: seed fetch, then ITER rounds of
// x <- x*(2 - d*x) on a shared multiplier.
module recip_nr_ctrl
  import recip_pkg::*;
#(
  parameter int ITER = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [15:0]            d,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [15:0]            q,
  output logic [6:0]             seed_idx,
  input  logic [7:0]             seed_in,
  recip_nr_ctrl_if.master        mul
);

  localparam logic [1:0] ITER_C = 2'(ITER);

  state_t      state;
  logic [1:0]  cnt;
  logic [15:0] d_lat;
  logic [15:0] x;
  logic [16:0] p_hi;

  // Low product bits and seed MSB are discarded by the Q1.15 truncation.
  logic unused_bits;
  assign unused_bits = ^{seed_in[7], mul.mul_p[14:0]};

  assign p_hi = mul.mul_p[31:15];

  function automatic logic [15:0] sat_q15(input logic [16:0] ph);
    return ph[16] ? SAT_Q15 : ph[15:0];
  endfunction

  function automatic logic [15:0] two_minus(input logic [15:0] t);
    return 16'(TWO_Q15 - {1'b0, t});
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      q           <= '0;
      seed_idx    <= '0;
      mul.mul_req <= 1'b0;
      mul.mul_a   <= '0;
      mul.mul_b   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (d[15]) begin
              d_lat    <= d;
              seed_idx <= d[14:8];
              cnt      <= '0;
              err      <= 1'b0;
              busy     <= 1'b1;
              state    <= SEED;
            end else begin
              err   <= 1'b1;
              q     <= SAT_Q15;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        SEED: begin
          x           <= seed_expand(seed_in[6:0]);
          mul.mul_req <= 1'b1;
          mul.mul_a   <= d_lat;
          mul.mul_b   <= seed_expand(seed_in[6:0]);
          state       <= MUL1;
        end
        MUL1: begin
          if (mul.mul_ack) begin
            mul.mul_a <= x;
            mul.mul_b <= two_minus(p_hi[15:0]);
            state     <= MUL2;
          end
        end
        MUL2: begin
          if (mul.mul_ack) begin
            x   <= sat_q15(p_hi);
            cnt <= cnt + 2'd1;
            if (cnt + 2'd1 == ITER_C) begin
              mul.mul_req <= 1'b0;
              q           <= sat_q15(p_hi);
              done        <= 1'b1;
              busy        <= 1'b0;
              state       <= DONE;
            end else begin
              mul.mul_a <= d_lat;
              mul.mul_b <= sat_q15(p_hi);
              state     <= MUL1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/recip_nr_ctrl.md
# recip_nr_ctrl

Sequencing controller for the reciprocal unit. It accepts a normalized divisor and fetches an 8-bit seed from the external bipartite seed table. It then runs ITER Newton-Raphson iterations, x ← x·(2 − d·x), on one multiplier shared with other clients over a req/ack port. It sits between the divide front end and the shared 16×16 multiplier.

## Interface
- ITER, default 2: number of Newton-Raphson iterations; legal range 1..3.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- d  in  16  divisor, Q1.15; d[15] must be 1, so 1 ≤ d < 2.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when q is valid.
- err  out  1  valid with done; set when d[15]=0.
- q  out  16  reciprocal, Q1.15; held until the next accepted start.
- seed_idx  out  7  to the seed table input; registered d[14:8].
- seed_in  in  8  seed table output; combinational from seed_idx.
- mul_req  out  1  multiplier request.
- mul_a, mul_b  out  16  multiplier operands.
- mul_ack  in  1  product valid this cycle.
- mul_p  in  32  unsigned product, Q2.30.

## Operation
- FSM states: IDLE, SEED, MUL1, MUL2, DONE.
- IDLE + start with d[15]=1:
  - latch d;
  - seed_idx ← d[14:8];
  - iteration counter ← 0;
  - go to SEED.
- IDLE + start with d[15]=0: go to DONE with err=1 and q=16'hFFFF. No multiplier request is made.
- SEED, one cycle: x ← {1'b0, 1'b1, seed_in[6:0], 7'b0}, i.e. x0 = 0.5 + seed/256. Seed bit 7 is ignored. Go to MUL1.
- MUL1 computes t = d·x:
  - drive mul_a=d, mul_b=x, mul_req=1;
  - on mul_ack, t ← mul_p[30:15], truncated;
  - go to MUL2.
- MUL2 computes x·(2 − t):
  - drive mul_a=x, mul_b = 17'h10000 − t, truncated to 16 bits;
  - on mul_ack: if mul_p[31]=1, x ← 16'hFFFF (saturate); else x ← mul_p[30:15];
  - increment the counter;
  - if the counter reaches ITER, go to DONE; otherwise go to MUL1.
- DONE, one cycle: done=1 and q ← x; then return to IDLE.
- A start while busy is ignored and not queued.
- Multiplier handshake:
  - mul_req and the operands stay stable until the edge at which mul_ack=1 is sampled;
  - an ack in the same cycle req rises is legal;
  - mul_req is low in any cycle after the ack edge unless the next state requests again. MUL1→MUL2 keeps req high with new operands.
  - mul_ack while mul_req=0 is ignored.

## Timing
- Reset values: state=IDLE; busy=0, done=0, err=0, q=0, mul_req=0, mul_a=0, mul_b=0, seed_idx=0.
- Reset asserted mid-operation aborts at that edge. mul_req is low in the following cycle, and a pending ack is discarded.
- Start sampled at edge T:
  - SEED during T+1;
  - first MUL1 during T+2;
  - with zero-wait acks each multiply takes 1 cycle and done pulses at T+2+2·ITER;
  - each cycle with mul_ack=0 adds exactly one cycle.
- Error path: done and err pulse at T+1.
- q, err: registered; they update on the edge entering DONE and hold afterwards.
- busy drops in the same cycle done is high. A new start is accepted in the cycle after done.

## Structure
- Shared package recip_pkg holds:
  - the state enum;
  - the Q1.15 constants ONE_Q15=16'h8000, TWO_Q15=17'h10000, SAT_Q15=16'hFFFF;
  - the seed expansion function.
- No sub-module is needed. The controller is a single FSM with an iteration counter. The seed table and multiplier remain external instances wired at the parent.

## Test plan
- Bench seed model returns 8'h7F; start with d=16'h8000 and zero-wait ack -> MUL1 operands 8000/7F80, MUL2 operands 7F80/8080, q=16'h7FFF, done exactly 6 cycles after start.
- Seed 8'h2B; d=16'hC000 -> first iteration x=16'h5580→16'h5555, second stays 16'h5555, q=16'h5555.
- Same as the previous case with random 0–3 wait cycles per ack -> q=16'h5555; operands stay stable while mul_ack=0; latency = 6 + total wait cycles.
- d=16'h4000 -> done and err at T+1, q=16'hFFFF, mul_req never asserted.
- Reset pulse during the second MUL1 wait -> next cycle all outputs at reset values; a fresh start with d=16'h8000 completes normally with q=16'h7FFF.
- start pulses during busy, plus mul_ack pulses while mul_req=0 -> no effect on state or result; only the first start produces a done.
